// File: rtl/obi_mem_arbiter.sv
// obi_mem_arbiter
// Shares one single-port, synchronous-read SRAM between the core instruction
// and data OBI ports. Grants are combinational and responses come back after
// exactly one cycle, so the core never needs an outstanding-request queue.
// Conflicts are resolved round-robin. A saturating counter records how many
// cycles both ports were requesting at once.
module obi_mem_arbiter #(
  parameter int MEM_AW = 12,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  // instruction port
  input  logic              i_instr_req,
  input  logic [31:0]       i_instr_addr,
  output logic              o_instr_gnt,
  output logic              o_instr_rvalid,
  output logic [31:0]       o_instr_rdata,
  // data port
  input  logic              i_data_req,
  input  logic              i_data_we,
  input  logic [3:0]        i_data_be,
  input  logic [31:0]       i_data_addr,
  input  logic [31:0]       i_data_wdata,
  output logic              o_data_gnt,
  output logic              o_data_rvalid,
  output logic [31:0]       o_data_rdata,
  // SRAM side
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [3:0]        o_mem_be,
  output logic [MEM_AW-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  input  logic [31:0]       i_mem_rdata,
  // performance counter
  output logic [CNT_W-1:0]  o_conflict_cnt
);

  // 1 means the data port wins the next conflict
  logic             r_prioData;
  // one-cycle response pipeline flags
  logic             r_rspI;
  logic             r_rspD;
  logic             r_rspWr;
  logic [CNT_W-1:0] r_conflictCnt;

  logic             w_conflict;
  logic             w_instrGnt;
  logic             w_dataGnt;
  logic             w_unused;

  assign w_conflict = i_instr_req & i_data_req;

  // Byte-offset bits and address bits above the SRAM window are ignored.
  assign w_unused = ^{i_instr_addr[31:MEM_AW+2], i_instr_addr[1:0],
                      i_data_addr[31:MEM_AW+2], i_data_addr[1:0]};

  // Pick at most one winner per cycle; reset blocks every grant.
  always_comb begin
    w_instrGnt = 1'b0;
    w_dataGnt  = 1'b0;
    if (!i_rst) begin
      if (i_data_req && (!i_instr_req || r_prioData)) begin
        w_dataGnt = 1'b1;
      end else if (i_instr_req) begin
        w_instrGnt = 1'b1;
      end
    end
  end

  assign o_instr_gnt = w_instrGnt;
  assign o_data_gnt  = w_dataGnt;
  assign o_mem_en    = w_instrGnt | w_dataGnt;

  // Steer the winning port onto the SRAM; idle cycles drive zeros.
  always_comb begin
    o_mem_we    = 1'b0;
    o_mem_be    = 4'h0;
    o_mem_addr  = '0;
    o_mem_wdata = 32'h0;
    if (w_dataGnt) begin
      o_mem_we    = i_data_we;
      o_mem_be    = i_data_be;
      o_mem_addr  = i_data_addr[MEM_AW+1:2];
      o_mem_wdata = i_data_wdata;
    end else if (w_instrGnt) begin
      o_mem_be    = 4'hF;
      o_mem_addr  = i_instr_addr[MEM_AW+1:2];
    end
  end

  // Round-robin priority, response flags and the saturating conflict counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prioData    <= 1'b1;
      r_rspI        <= 1'b0;
      r_rspD        <= 1'b0;
      r_rspWr       <= 1'b0;
      r_conflictCnt <= '0;
    end else begin
      if (w_dataGnt) begin
        r_prioData <= 1'b0;
      end else if (w_instrGnt) begin
        r_prioData <= 1'b1;
      end
      r_rspI  <= w_instrGnt;
      r_rspD  <= w_dataGnt;
      r_rspWr <= w_dataGnt & i_data_we;
      if (w_conflict && (r_conflictCnt != {CNT_W{1'b1}})) begin
        r_conflictCnt <= r_conflictCnt + CNT_W'(1);
      end
    end
  end

  assign o_instr_rvalid = r_rspI;
  assign o_data_rvalid  = r_rspD;
  // Write acknowledgements carry no data, so the SRAM output is masked off.
  assign o_instr_rdata  = i_mem_rdata & {32{r_rspI}};
  assign o_data_rdata   = i_mem_rdata & {32{r_rspD & ~r_rspWr}};
  assign o_conflict_cnt = r_conflictCnt;

endmodule
